// File: rtl/blink_rate_meter.sv
// rtl/blink_rate_meter.sv - measures the half-period of an async square wave in prescaler ticks
module blink_rate_meter #(
  parameter int PRESCALE_W = 17,
  parameter int RATE_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_blink_in,
  output logic [RATE_W-1:0] o_rate,
  output logic              o_rate_valid,
  output logic              o_locked,
  output logic              o_timeout
);

  localparam logic [RATE_W-1:0] RATE_MAX = '1;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_MEASURE = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic r_s1;
  logic r_s2;
  logic r_p;
  logic w_edge;

  logic [PRESCALE_W-1:0] r_presc;
  logic [RATE_W-1:0]     r_ticks;
  logic                  w_presc_full;
  logic [RATE_W-1:0]     w_value;

  logic w_ovf;
  logic w_meas;
  logic w_lock_new;
  logic w_fire;

  logic [RATE_W-1:0] r_rate;
  logic              r_rate_valid;
  logic              r_locked;
  logic              r_timeout;
  logic [RATE_W-1:0] r_prev_rate;
  logic              r_have_prev;
  logic              r_pend;
  logic [RATE_W-1:0] r_pend_rate;
  logic              r_pend_lock;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_p  <= 1'b0;
    end else begin
      r_s1 <= i_blink_in;
      r_s2 <= r_s1;
      r_p  <= r_s2;
    end
  end

  assign w_edge       = r_s2 ^ r_p;
  assign w_presc_full = &r_presc;
  // Counting the pending wrap makes the reported value floor(N / 2^PRESCALE_W).
  assign w_value      = r_ticks + {{(RATE_W-1){1'b0}}, w_presc_full};

  always_ff @(posedge clk) begin
    if (rst || w_edge) begin
      r_presc <= '0;
      r_ticks <= '0;
    end else begin
      r_presc <= r_presc + {{(PRESCALE_W-1){1'b0}}, 1'b1};
      if (w_presc_full) begin
        r_ticks <= r_ticks + {{(RATE_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Overflow is checked before the edge so a coincident edge neither strobes nor arms.
  always_comb begin
    w_state_nxt = r_state;
    w_ovf       = 1'b0;
    w_meas      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_edge) begin
          w_state_nxt = S_MEASURE;
        end
      end
      S_MEASURE: begin
        if ((r_ticks == RATE_MAX) && w_presc_full) begin
          w_ovf       = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_edge) begin
          w_meas = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_lock_new = r_have_prev && (w_value == r_prev_rate);
  // A measurement landing while the strobe is high is held one cycle so strobes never abut.
  assign w_fire     = !r_rate_valid && (r_pend || w_meas);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rate       <= '0;
      r_rate_valid <= 1'b0;
      r_locked     <= 1'b0;
      r_timeout    <= 1'b0;
      r_prev_rate  <= '0;
      r_have_prev  <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_rate  <= '0;
      r_pend_lock  <= 1'b0;
    end else begin
      r_rate_valid <= w_fire;
      if (w_meas) begin
        r_prev_rate <= w_value;
        r_have_prev <= 1'b1;
      end
      if (w_fire) begin
        r_timeout <= 1'b0;
        if (r_pend) begin
          r_rate   <= r_pend_rate;
          r_locked <= r_pend_lock;
        end else begin
          r_rate   <= w_value;
          r_locked <= w_lock_new;
        end
      end
      if (w_meas && (r_rate_valid || r_pend)) begin
        r_pend      <= 1'b1;
        r_pend_rate <= w_value;
        r_pend_lock <= w_lock_new;
      end else if (w_fire) begin
        r_pend <= 1'b0;
      end
      if (w_ovf) begin
        r_timeout   <= 1'b1;
        r_locked    <= 1'b0;
        r_have_prev <= 1'b0;
        r_pend      <= 1'b0;
      end
    end
  end

  assign o_rate       = r_rate;
  assign o_rate_valid = r_rate_valid;
  assign o_locked     = r_locked;
  assign o_timeout    = r_timeout;

endmodule

// File: tb/tb_blink_rate_meter.sv
// tb/tb_blink_rate_meter.sv - directed bench for blink_rate_meter (tick=16 clk, RATE_MAX=15)
module tb_blink_rate_meter;

  logic       clk;
  logic       rst;
  logic       blink;
  logic [3:0] rate;
  logic       rv;
  logic       lk;
  logic       to;

  int checks;
  int errors;
  int cyc;
  int dbl;
  logic prev_rv;

  logic [3:0] ev_rate[$];
  logic       ev_lock[$];
  logic       ev_to[$];
  int         ev_cyc[$];

  blink_rate_meter #(.PRESCALE_W(4), .RATE_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_blink_in  (blink),
    .o_rate      (rate),
    .o_rate_valid(rv),
    .o_locked    (lk),
    .o_timeout   (to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    dbl     = 0;
    prev_rv = 1'b0;
  end

  always @(negedge clk) begin
    if (rv) begin
      ev_rate.push_back(rate);
      ev_lock.push_back(lk);
      ev_to.push_back(to);
      ev_cyc.push_back(cyc);
      if (prev_rv) dbl = dbl + 1;
    end
    prev_rv = rv;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_ev();
    ev_rate.delete();
    ev_lock.delete();
    ev_to.delete();
    ev_cyc.delete();
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    blink = 1'b0;
    step(3);
    rst = 1'b0;
    step(2);
    clear_ev();
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    blink = 1'b0;
    step(3);
    checks++; if (rate !== 4'd0) begin errors++; $display("FAIL reset_rate got %0d want 0", rate); end
    checks++; if (rv !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rv); end
    checks++; if (lk !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", lk); end
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", to); end
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_steady();
    int tc[4];
    do_reset();
    step(5);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step(48);
      blink = ~blink;
      tc[i] = cyc;
    end
    step(10);
    checks++;
    if (ev_rate.size() != 3) begin
      errors++; $display("FAIL steady_count got %0d want 3", ev_rate.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (ev_rate[i] !== 4'd3) begin errors++; $display("FAIL steady_rate[%0d] got %0d want 3", i, ev_rate[i]); end
        checks++; if (ev_lock[i] !== (i > 0)) begin errors++; $display("FAIL steady_locked[%0d] got %b want %b", i, ev_lock[i], (i > 0)); end
        checks++; if (ev_cyc[i] != tc[i+1] + 3) begin errors++; $display("FAIL steady_latency[%0d] got %0d want %0d", i, ev_cyc[i], tc[i+1] + 3); end
      end
    end
  endtask

  task automatic test_rates();
    int gaps[6]     = '{47, 64, 48, 64, 48, 64};
    int exp_rate[6] = '{2, 4, 3, 4, 3, 4};
    do_reset();
    step(5);
    blink = ~blink;
    for (int i = 0; i < 6; i++) begin
      step(gaps[i]);
      blink = ~blink;
    end
    step(10);
    checks++;
    if (ev_rate.size() != 6) begin
      errors++; $display("FAIL rates_count got %0d want 6", ev_rate.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (ev_rate[i] !== 4'(exp_rate[i])) begin errors++; $display("FAIL rates_rate[%0d] got %0d want %0d", i, ev_rate[i], exp_rate[i]); end
        checks++; if (ev_lock[i] !== 1'b0) begin errors++; $display("FAIL rates_locked[%0d] got %b want 0", i, ev_lock[i]); end
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    step(5);
    blink = ~blink;
    step(48);
    blink = ~blink;
    step(258);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL timeout_early got %b want 0", to); end
    step(1);
    checks++; if (to !== 1'b1) begin errors++; $display("FAIL timeout_rise got %b want 1", to); end
    checks++; if (lk !== 1'b0) begin errors++; $display("FAIL timeout_locked got %b want 0", lk); end
    checks++; if (rate !== 4'd3) begin errors++; $display("FAIL timeout_rate_hold got %0d want 3", rate); end
    clear_ev();
    step(20);
    blink = ~blink;
    step(47);
    checks++; if (to !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b want 1", to); end
    checks++; if (ev_rate.size() != 0) begin errors++; $display("FAIL timeout_arm_strobe got %0d want 0", ev_rate.size()); end
    step(1);
    blink = ~blink;
    step(5);
    checks++;
    if (ev_rate.size() != 1) begin
      errors++; $display("FAIL timeout_resume_count got %0d want 1", ev_rate.size());
    end else begin
      checks++; if (ev_rate[0] !== 4'd3) begin errors++; $display("FAIL timeout_resume_rate got %0d want 3", ev_rate[0]); end
      checks++; if (ev_to[0] !== 1'b0) begin errors++; $display("FAIL timeout_resume_clear got %b want 0", ev_to[0]); end
      checks++; if (ev_lock[0] !== 1'b0) begin errors++; $display("FAIL timeout_resume_locked got %b want 0", ev_lock[0]); end
    end
  endtask

  task automatic test_boundary();
    do_reset();
    step(5);
    blink = ~blink;
    step(255);
    blink = ~blink;
    step(5);
    checks++;
    if (ev_rate.size() != 1) begin
      errors++; $display("FAIL bound_255_count got %0d want 1", ev_rate.size());
    end else begin
      checks++; if (ev_rate[0] !== 4'd15) begin errors++; $display("FAIL bound_255_rate got %0d want 15", ev_rate[0]); end
      checks++; if (ev_to[0] !== 1'b0) begin errors++; $display("FAIL bound_255_timeout got %b want 0", ev_to[0]); end
    end
    clear_ev();
    step(251);
    blink = ~blink;
    step(10);
    checks++; if (ev_rate.size() != 0) begin errors++; $display("FAIL bound_256_strobe got %0d want 0", ev_rate.size()); end
    checks++; if (to !== 1'b1) begin errors++; $display("FAIL bound_256_timeout got %b want 1", to); end
    step(10);
    blink = ~blink;
    step(48);
    blink = ~blink;
    step(5);
    checks++;
    if (ev_rate.size() != 1) begin
      errors++; $display("FAIL bound_rearm_count got %0d want 1", ev_rate.size());
    end else begin
      checks++; if (ev_rate[0] !== 4'd3) begin errors++; $display("FAIL bound_rearm_rate got %0d want 3", ev_rate[0]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(5);
    blink = ~blink;
    step(48);
    blink = ~blink;
    step(24);
    rst = 1'b1;
    step(2);
    checks++; if (rate !== 4'd0) begin errors++; $display("FAIL rstmid_rate got %0d want 0", rate); end
    checks++; if (rv !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", rv); end
    checks++; if (lk !== 1'b0) begin errors++; $display("FAIL rstmid_locked got %b want 0", lk); end
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL rstmid_timeout got %b want 0", to); end
    rst = 1'b0;
    step(2);
    clear_ev();
    step(22);
    blink = ~blink;
    step(48);
    blink = ~blink;
    step(5);
    checks++;
    if (ev_rate.size() != 1) begin
      errors++; $display("FAIL rstmid_count got %0d want 1", ev_rate.size());
    end else begin
      checks++; if (ev_rate[0] !== 4'd3) begin errors++; $display("FAIL rstmid_rate_after got %0d want 3", ev_rate[0]); end
      checks++; if (ev_lock[0] !== 1'b0) begin errors++; $display("FAIL rstmid_locked_after got %b want 0", ev_lock[0]); end
    end
  endtask

  task automatic test_glitch();
    int g1;
    logic [3:0] exp_rate[4] = '{4'd3, 4'd0, 4'd0, 4'd3};
    logic       exp_lock[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    step(5);
    blink = ~blink;
    step(48);
    blink = ~blink;
    step(5);
    blink = 1'b1;
    g1 = cyc;
    step(1);
    blink = 1'b0;
    step(48);
    blink = ~blink;
    step(10);
    checks++;
    if (ev_rate.size() != 4) begin
      errors++; $display("FAIL glitch_count got %0d want 4", ev_rate.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (ev_rate[i] !== exp_rate[i]) begin errors++; $display("FAIL glitch_rate[%0d] got %0d want %0d", i, ev_rate[i], exp_rate[i]); end
        checks++; if (ev_lock[i] !== exp_lock[i]) begin errors++; $display("FAIL glitch_locked[%0d] got %b want %b", i, ev_lock[i], exp_lock[i]); end
      end
      checks++; if (ev_cyc[1] != g1 + 3) begin errors++; $display("FAIL glitch_first_cyc got %0d want %0d", ev_cyc[1], g1 + 3); end
      checks++; if (ev_cyc[2] != g1 + 5) begin errors++; $display("FAIL glitch_second_cyc got %0d want %0d", ev_cyc[2], g1 + 5); end
    end
    checks++; if (dbl != 0) begin errors++; $display("FAIL valid_double_width got %0d want 0", dbl); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    blink  = 1'b0;
    test_reset();
    test_steady();
    test_rates();
    test_timeout();
    test_boundary();
    test_reset_mid();
    test_glitch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
